// File: rtl/cache_arbiter.sv
// ============================================================================
// cache_arbiter: shares one memory port between I-cache (A) and D-cache (B)
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              a_read_i,
  input  logic              a_write_i,
  input  logic [ADDR_W-1:0] a_address_i,
  input  logic [LINE_W-1:0] a_wdata_i,
  output logic [LINE_W-1:0] a_rdata_o,
  output logic              a_resp_o,
  input  logic              b_read_i,
  input  logic              b_write_i,
  input  logic [ADDR_W-1:0] b_address_i,
  input  logic [LINE_W-1:0] b_wdata_i,
  output logic [LINE_W-1:0] b_rdata_o,
  output logic              b_resp_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_resp_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_b_q, last_b_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                req_a, req_b;
  logic                take_a, take_b;

  assign req_a = a_read_i | a_write_i;
  assign req_b = b_read_i | b_write_i;

  always_comb begin
    state_d       = state_q;
    last_b_d      = last_b_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    take_a        = 1'b0;
    take_b        = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie, the requester that was not served last wins.
        if (req_a && (!req_b || last_b_q)) take_a = 1'b1;
        else if (req_b)                    take_b = 1'b1;
      end
      SERVE_A: begin
        if (mem_resp_i) begin
          last_b_d = 1'b0;
          if (req_b) begin
            take_b = 1'b1;
          end else begin
            state_d     = IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
          end
        end
      end
      SERVE_B: begin
        if (mem_resp_i) begin
          last_b_d = 1'b1;
          if (req_a) begin
            take_a = 1'b1;
          end else begin
            state_d     = IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase

    // A simultaneous read and write is resolved as a write.
    if (take_a) begin
      state_d       = SERVE_A;
      mem_address_d = a_address_i;
      mem_wdata_d   = a_wdata_i;
      mem_write_d   = a_write_i;
      mem_read_d    = a_read_i & ~a_write_i;
    end else if (take_b) begin
      state_d       = SERVE_B;
      mem_address_d = b_address_i;
      mem_wdata_d   = b_wdata_i;
      mem_write_d   = b_write_i;
      mem_read_d    = b_read_i & ~b_write_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      last_b_q      <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_b_q      <= last_b_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign a_resp_o      = (state_q == SERVE_A) & mem_resp_i;
  assign b_resp_o      = (state_q == SERVE_B) & mem_resp_i;
  assign a_rdata_o     = mem_rdata_i;
  assign b_rdata_o     = mem_rdata_i;
  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;
  assign mem_address_o = mem_address_q;
  assign mem_wdata_o   = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// ============================================================================
// tb_cache_arbiter: directed self-checking bench for cache_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cache_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              a_read, a_write, b_read, b_write;
  logic [ADDR_W-1:0] a_address, b_address;
  logic [LINE_W-1:0] a_wdata, b_wdata;
  logic [LINE_W-1:0] a_rdata, b_rdata;
  logic              a_resp, b_resp;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk), .reset_i(reset),
    .a_read_i(a_read), .a_write_i(a_write), .a_address_i(a_address),
    .a_wdata_i(a_wdata), .a_rdata_o(a_rdata), .a_resp_o(a_resp),
    .b_read_i(b_read), .b_write_i(b_write), .b_address_i(b_address),
    .b_wdata_i(b_wdata), .b_rdata_o(b_rdata), .b_resp_o(b_resp),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_address_o(mem_address),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    a_read = 0; a_write = 0; b_read = 0; b_write = 0;
    a_address = '0; b_address = '0; a_wdata = '0; b_wdata = '0;
    mem_rdata = '0; mem_resp = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read got=%b exp=0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
    checks++; if (mem_address !== '0) begin failures++; $display("FAIL reset_mem_address got=%h exp=0", mem_address); end
    checks++; if (mem_wdata !== '0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (a_resp !== 1'b0 || b_resp !== 1'b0) begin failures++; $display("FAIL reset_resp got=%b%b exp=00", a_resp, b_resp); end
  endtask

  task automatic test_single_read();
    logic [LINE_W-1:0] line;
    do_reset();
    line = {8{32'hCAFE_0001}};
    a_read = 1; a_address = 32'h100;
    @(negedge clk);
    checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin failures++; $display("FAIL single_cmd got rd=%b wr=%b exp rd=1 wr=0", mem_read, mem_write); end
    checks++; if (mem_address !== 32'h100) begin failures++; $display("FAIL single_addr got=%h exp=100", mem_address); end
    @(negedge clk);
    checks++; if (a_resp !== 1'b0) begin failures++; $display("FAIL single_early_resp got=%b exp=0", a_resp); end
    @(negedge clk);
    mem_resp = 1; mem_rdata = line;
    #1;
    checks++; if (a_resp !== 1'b1 || b_resp !== 1'b0) begin failures++; $display("FAIL single_resp got a=%b b=%b exp a=1 b=0", a_resp, b_resp); end
    checks++; if (a_rdata !== line) begin failures++; $display("FAIL single_rdata got=%h exp=%h", a_rdata, line); end
    @(negedge clk);
    mem_resp = 0; a_read = 0;
    checks++; if (mem_read !== 1'b0 || a_resp !== 1'b0) begin failures++; $display("FAIL single_after got rd=%b resp=%b exp 0 0", mem_read, a_resp); end
  endtask

  task automatic test_tie_handoff();
    logic [LINE_W-1:0] w1;
    do_reset();
    w1 = {8{32'h1234_5678}};
    a_read = 1; a_address = 32'h200;
    b_write = 1; b_address = 32'h300; b_wdata = w1;
    @(negedge clk);
    checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin failures++; $display("FAIL tie_b_cmd got rd=%b wr=%b exp rd=0 wr=1", mem_read, mem_write); end
    checks++; if (mem_address !== 32'h300) begin failures++; $display("FAIL tie_b_addr got=%h exp=300", mem_address); end
    checks++; if (mem_wdata !== w1) begin failures++; $display("FAIL tie_b_wdata got=%h exp=%h", mem_wdata, w1); end
    mem_resp = 1;
    #1;
    checks++; if (b_resp !== 1'b1 || a_resp !== 1'b0) begin failures++; $display("FAIL tie_b_resp got a=%b b=%b exp a=0 b=1", a_resp, b_resp); end
    @(negedge clk);
    mem_resp = 0; b_write = 0;
    checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin failures++; $display("FAIL handoff_cmd got rd=%b wr=%b exp rd=1 wr=0", mem_read, mem_write); end
    checks++; if (mem_address !== 32'h200) begin failures++; $display("FAIL handoff_addr got=%h exp=200", mem_address); end
    mem_resp = 1;
    #1;
    checks++; if (a_resp !== 1'b1 || b_resp !== 1'b0) begin failures++; $display("FAIL handoff_resp got a=%b b=%b exp a=1 b=0", a_resp, b_resp); end
    @(negedge clk);
    mem_resp = 0; a_read = 0;
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL handoff_idle got rd=%b wr=%b exp 0 0", mem_read, mem_write); end
  endtask

  task automatic test_alternation();
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_b;
    do_reset();
    a_read = 1; a_address = 32'hA000;
    b_read = 1; b_address = 32'hB000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_resp = 0;
      exp_b    = (i % 2 == 0);
      exp_addr = exp_b ? 32'hB000 : 32'hA000;
      checks++; if (mem_address !== exp_addr || mem_read !== 1'b1) begin failures++; $display("FAIL alt_grant%0d got addr=%h rd=%b exp addr=%h rd=1", i, mem_address, mem_read, exp_addr); end
      mem_resp = 1;
      #1;
      checks++; if (b_resp !== exp_b || a_resp !== !exp_b) begin failures++; $display("FAIL alt_resp%0d got a=%b b=%b exp a=%b b=%b", i, a_resp, b_resp, !exp_b, exp_b); end
    end
    @(negedge clk);
    mem_resp = 0; a_read = 0; b_read = 0;
  endtask

  task automatic test_addr_change();
    do_reset();
    a_read = 1; a_address = 32'h400;
    @(negedge clk);
    checks++; if (mem_address !== 32'h400) begin failures++; $display("FAIL hold_first got=%h exp=400", mem_address); end
    a_address = 32'h500; a_read = 0; a_write = 1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_address !== 32'h400) begin failures++; $display("FAIL hold_addr got=%h exp=400", mem_address); end
    checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin failures++; $display("FAIL hold_cmd got rd=%b wr=%b exp rd=1 wr=0", mem_read, mem_write); end
    mem_resp = 1;
    #1;
    checks++; if (a_resp !== 1'b1) begin failures++; $display("FAIL hold_resp got=%b exp=1", a_resp); end
    @(negedge clk);
    mem_resp = 0; a_write = 0;
  endtask

  task automatic test_write_wins();
    do_reset();
    b_read = 1; b_write = 1; b_address = 32'hC00;
    @(negedge clk);
    checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin failures++; $display("FAIL write_wins got rd=%b wr=%b exp rd=0 wr=1", mem_read, mem_write); end
    mem_resp = 1;
    @(negedge clk);
    mem_resp = 0; b_read = 0; b_write = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    b_write = 1; b_address = 32'h600; b_wdata = {8{32'hDEAD_BEEF}};
    @(negedge clk);
    checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL midrst_pre got wr=%b exp=1", mem_write); end
    reset = 1; b_write = 0;
    @(negedge clk);
    reset = 0;
    checks++; if (mem_write !== 1'b0 || mem_address !== '0) begin failures++; $display("FAIL midrst_cleared got wr=%b addr=%h exp wr=0 addr=0", mem_write, mem_address); end
    mem_resp = 1;
    #1;
    checks++; if (b_resp !== 1'b0 || a_resp !== 1'b0) begin failures++; $display("FAIL midrst_stray got a=%b b=%b exp 0 0", a_resp, b_resp); end
    @(negedge clk);
    mem_resp = 0;
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL midrst_idle got rd=%b wr=%b exp 0 0", mem_read, mem_write); end
    a_read = 1; a_address = 32'h700;
    b_read = 1; b_address = 32'h800;
    @(negedge clk);
    checks++; if (mem_address !== 32'h800) begin failures++; $display("FAIL midrst_tie got=%h exp=800", mem_address); end
    a_read = 0; b_read = 0;
  endtask

  task automatic test_idle_resp();
    do_reset();
    mem_resp = 1;
    #1;
    checks++; if (a_resp !== 1'b0 || b_resp !== 1'b0) begin failures++; $display("FAIL idle_resp got a=%b b=%b exp 0 0", a_resp, b_resp); end
    @(negedge clk);
    mem_resp = 0;
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL idle_stay got rd=%b wr=%b exp 0 0", mem_read, mem_write); end
    a_read = 1; a_address = 32'h900;
    @(negedge clk);
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'h900) begin failures++; $display("FAIL idle_next got rd=%b addr=%h exp rd=1 addr=900", mem_read, mem_address); end
    a_read = 0;
  endtask

  initial begin
    reset = 1;
    a_read = 0; a_write = 0; b_read = 0; b_write = 0;
    a_address = '0; b_address = '0; a_wdata = '0; b_wdata = '0;
    mem_rdata = '0; mem_resp = 0;
    test_reset();
    test_single_read();
    test_tie_handoff();
    test_alternation();
    test_addr_change();
    test_write_wins();
    test_reset_mid();
    test_idle_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
